coin_change_dispenser: RTL and testbench

- Downstream stage of the vending machine FSM. Consumes the 8-bit change amount the FSM computes when a product is dispensed.
- Pays the change out as physical coins, one eject pulse at a time, using a greedy largest-coin-first policy.
- Tracks a per-denomination coin inventory, supports refill while idle, and reports any amount it cannot pay.

---
 rtl/coin_change_dispenser.sv | 188 ++++++++++++++++++
 tb/tb_coin_change_dispenser.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_change_dispenser.sv
// Coin change dispenser: pays a change amount as individual coin ejects using a
// greedy largest-coin-first policy, with a per-denomination inventory, an idle-only
// refill port and shortfall reporting when the inventory cannot cover the amount.
// Every output is a registered image of the state just left, so coin_eject, done
// and the short flags appear one cycle after the corresponding state is entered.

module coin_change_dispenser #(
  parameter int unsigned INIT_COUNT = 15,
  parameter int unsigned EJECT_GAP  = 2
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       change_valid,
  input  logic [7:0] change_amount,
  input  logic       refill_en,
  input  logic [2:0] refill_code,
  input  logic [7:0] refill_qty,
  output logic       busy,
  output logic       coin_eject,
  output logic [2:0] coin_code,
  output logic       done,
  output logic       short_err,
  output logic [7:0] shortfall,
  output logic [5:0] coin_empty
);

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StEject,
    StGap,
    StDone
  } state_e;

  localparam logic [7:0] InitCnt   = 8'(INIT_COUNT);
  localparam logic [3:0] GapLast   = 4'(EJECT_GAP - 1);
  localparam bit         HasGap    = (EJECT_GAP > 0);
  localparam logic [5:0] EmptyInit = (INIT_COUNT == 0) ? 6'h3f : 6'h00;

  function automatic logic [7:0] coin_value(input logic [2:0] code);
    logic [7:0] v;
    case (code)
      3'd0:    v = 8'd50;
      3'd1:    v = 8'd20;
      3'd2:    v = 8'd10;
      3'd3:    v = 8'd5;
      3'd4:    v = 8'd2;
      3'd5:    v = 8'd1;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  state_e     state_q, state_d;
  logic [7:0] remaining_q, remaining_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] gap_q, gap_d;
  logic [7:0] count_q [6];
  logic [7:0] count_d [6];

  logic       busy_d, coin_eject_d, done_d, short_err_d;
  logic [2:0] coin_code_d;
  logic [7:0] shortfall_d;
  logic [5:0] coin_empty_d;

  logic       pick_found;
  logic [2:0] pick_code;
  logic [8:0] refill_sum;

  // Greedy pick: lowest code (largest value) that fits the remainder and is in stock.
  always_comb begin
    pick_found = 1'b0;
    pick_code  = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if ((count_q[i] != 8'd0) && (coin_value(3'(i)) <= remaining_q)) begin
        pick_found = 1'b1;
        pick_code  = 3'(i);
      end
    end
  end

  // Next-state, inventory and registered-output computation.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    sel_d        = sel_q;
    gap_d        = gap_q;
    count_d      = count_q;
    short_err_d  = short_err;
    shortfall_d  = shortfall;
    refill_sum   = 9'd0;
    coin_empty_d = 6'd0;

    unique case (state_q)
      StIdle: begin
        // Refill is applied first so a same-edge request sees the new count.
        if (refill_en && (refill_code <= 3'd5)) begin
          refill_sum             = {1'b0, count_q[refill_code]} + {1'b0, refill_qty};
          count_d[refill_code]   = refill_sum[8] ? 8'hff : refill_sum[7:0];
        end
        if (change_valid) begin
          remaining_d = change_amount;
          short_err_d = 1'b0;
          shortfall_d = 8'd0;
          state_d     = (change_amount == 8'd0) ? StDone : StSelect;
        end
      end
      StSelect: begin
        if (pick_found) begin
          sel_d   = pick_code;
          state_d = StEject;
        end else begin
          state_d = StDone;
        end
      end
      StEject: begin
        count_d[sel_q] = count_q[sel_q] - 8'd1;
        remaining_d    = remaining_q - coin_value(sel_q);
        gap_d          = 4'd0;
        if (remaining_d == 8'd0) begin
          state_d = StDone;
        end else if (HasGap) begin
          state_d = StGap;
        end else begin
          state_d = StSelect;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StSelect;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      StDone: begin
        // Whatever is left unpaid at this point is the shortfall.
        short_err_d = (remaining_q != 8'd0);
        shortfall_d = remaining_q;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    for (int i = 0; i < 6; i++) begin
      coin_empty_d[i] = (count_d[i] == 8'd0);
    end

    coin_eject_d = (state_q == StEject);
    coin_code_d  = (state_q == StEject) ? sel_q : coin_code;
    done_d       = (state_q == StDone);
    // Busy covers the done pulse as well.
    busy_d       = (state_d != StIdle) || (state_q == StDone);
  end

  // State, inventory and output registers.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      remaining_q <= 8'd0;
      sel_q       <= 3'd0;
      gap_q       <= 4'd0;
      for (int i = 0; i < 6; i++) begin
        count_q[i] <= InitCnt;
      end
      busy        <= 1'b0;
      coin_eject  <= 1'b0;
      coin_code   <= 3'd0;
      done        <= 1'b0;
      short_err   <= 1'b0;
      shortfall   <= 8'd0;
      coin_empty  <= EmptyInit;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      sel_q       <= sel_d;
      gap_q       <= gap_d;
      count_q     <= count_d;
      busy        <= busy_d;
      coin_eject  <= coin_eject_d;
      coin_code   <= coin_code_d;
      done        <= done_d;
      short_err   <= short_err_d;
      shortfall   <= shortfall_d;
      coin_empty  <= coin_empty_d;
    end
  end

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Bench for coin_change_dispenser: a schedule-level model of the default-parameter
// instance checked every cycle, plus literal expectations on both instances.

module tb_coin_change_dispenser;

  localparam int G    = 2;
  localparam int INIT = 15;

  logic       clock = 1'b0;
  logic       rst   = 1'b0;

  logic       change_valid = 1'b0, refill_en = 1'b0;
  logic [7:0] change_amount = 8'd0, refill_qty = 8'd0;
  logic [2:0] refill_code = 3'd0;
  logic       busy, coin_eject, done, short_err;
  logic [2:0] coin_code;
  logic [7:0] shortfall;
  logic [5:0] coin_empty;

  logic       change_valid2 = 1'b0, refill_en2 = 1'b0;
  logic [7:0] change_amount2 = 8'd0, refill_qty2 = 8'd0;
  logic [2:0] refill_code2 = 3'd0;
  logic       busy2, coin_eject2, done2, short_err2;
  logic [2:0] coin_code2;
  logic [7:0] shortfall2;
  logic [5:0] coin_empty2;

  coin_change_dispenser #(.INIT_COUNT(INIT), .EJECT_GAP(G)) dut (
    .clock(clock), .rst(rst), .change_valid(change_valid), .change_amount(change_amount),
    .refill_en(refill_en), .refill_code(refill_code), .refill_qty(refill_qty),
    .busy(busy), .coin_eject(coin_eject), .coin_code(coin_code), .done(done),
    .short_err(short_err), .shortfall(shortfall), .coin_empty(coin_empty)
  );

  coin_change_dispenser #(.INIT_COUNT(1), .EJECT_GAP(G)) dut2 (
    .clock(clock), .rst(rst), .change_valid(change_valid2), .change_amount(change_amount2),
    .refill_en(refill_en2), .refill_code(refill_code2), .refill_qty(refill_qty2),
    .busy(busy2), .coin_eject(coin_eject2), .coin_code(coin_code2), .done(done2),
    .short_err(short_err2), .shortfall(shortfall2), .coin_empty(coin_empty2)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model state: inventory, expected eject schedule and done/busy window.
  int   mcount [6];
  int   m_e0, done_cyc;
  int   ej_cyc[$];
  int   ej_code[$];
  logic m_short, pend_short;
  int   m_shortfall, pend_shortfall;

  // Observations used by the literal checks.
  int   act_ej_cyc[$];
  int   act_ej_code[$];
  int   done_seen, busy_seen;
  int   codes2[$];
  int   done2_seen;
  logic d2_short;
  int   d2_fall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  function automatic int coin_val(input int d);
    case (d)
      0: return 50;
      1: return 20;
      2: return 10;
      3: return 5;
      4: return 2;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 6; d++) mcount[d] = INIT;
    m_e0 = 0;
    done_cyc = -1;
    ej_cyc.delete();
    ej_code.delete();
    m_short = 1'b0;
    pend_short = 1'b0;
    m_shortfall = 0;
    pend_shortfall = 0;
  endtask

  // Expected timeline for a request accepted at edge e: first coin at e+2, coins G+2
  // apart, done one cycle after the last coin (full pay) or after the failing pick.
  task automatic model_accept(input int e, input int amount);
    int cnt [6];
    int rem, s, pick;
    for (int d = 0; d < 6; d++) cnt[d] = mcount[d];
    m_e0 = e;
    m_short = 1'b0;
    m_shortfall = 0;
    rem = amount;
    s = e + 1;
    if (amount == 0) begin
      done_cyc = e + 1;
      pend_short = 1'b0;
      pend_shortfall = 0;
    end else begin
      while (1) begin
        pick = -1;
        for (int d = 0; d < 6; d++) if (pick < 0 && cnt[d] > 0 && coin_val(d) <= rem) pick = d;
        if (pick < 0) begin
          done_cyc = s + 1;
          pend_short = 1'b1;
          pend_shortfall = rem;
          break;
        end
        ej_cyc.push_back(s + 1);
        ej_code.push_back(pick);
        cnt[pick]--;
        rem -= coin_val(pick);
        if (rem == 0) begin
          done_cyc = s + 2;
          pend_short = 1'b0;
          pend_shortfall = 0;
          break;
        end
        s = s + 2 + G;
      end
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin : compare_proc
    bit         exp_ej;
    int         exp_code;
    logic [5:0] exp_empty;
    forever begin
      @(negedge clock);
      exp_ej = 1'b0;
      exp_code = 0;
      if (ej_cyc.size() > 0 && ej_cyc[0] == cyc) begin
        exp_ej = 1'b1;
        exp_code = ej_code.pop_front();
        void'(ej_cyc.pop_front());
        mcount[exp_code]--;
      end
      if (cyc == done_cyc) begin
        m_short = pend_short;
        m_shortfall = pend_shortfall;
      end
      for (int d = 0; d < 6; d++) exp_empty[d] = (mcount[d] == 0);
      chk("busy", busy, (cyc >= m_e0 && cyc <= done_cyc));
      chk("coin_eject", coin_eject, exp_ej);
      if (exp_ej) chk("coin_code", coin_code, exp_code);
      chk("done", done, (cyc == done_cyc));
      chk("short_err", short_err, m_short);
      chk("shortfall", shortfall, m_shortfall);
      chk("coin_empty", coin_empty, exp_empty);
      if (coin_eject) begin
        act_ej_cyc.push_back(cyc);
        act_ej_code.push_back(coin_code);
      end
      if (done) done_seen++;
      if (busy) busy_seen++;
      if (coin_eject2) codes2.push_back(coin_code2);
      if (done2) begin
        done2_seen++;
        d2_short = short_err2;
        d2_fall = shortfall2;
      end
    end
  end

  // Drives one edge of stimulus on the main instance; returns at negedge+1 after it.
  task automatic drive1(input bit v, input int amt, input bit r, input int code, input int qty,
                        output int e);
    change_valid = v;
    change_amount = 8'(amt);
    refill_en = r;
    refill_code = 3'(code);
    refill_qty = 8'(qty);
    e = cyc + 1;
    if (e > done_cyc) begin
      if (r && code <= 5) mcount[code] = (mcount[code] + qty > 255) ? 255 : mcount[code] + qty;
      if (v) model_accept(e, amt);
    end
    @(negedge clock);
    #1;
    change_valid = 1'b0;
    refill_en = 1'b0;
  endtask

  task automatic drive2(input bit v, input int amt, input bit r, input int code, input int qty);
    change_valid2 = v;
    change_amount2 = 8'(amt);
    refill_en2 = r;
    refill_code2 = 3'(code);
    refill_qty2 = 8'(qty);
    @(negedge clock);
    #1;
    change_valid2 = 1'b0;
    refill_en2 = 1'b0;
  endtask

  task automatic wait_idle1(input int budget);
    int n = 0;
    while (cyc <= done_cyc && n < budget) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (n >= budget) timeout_fail("wait_idle");
  endtask

  task automatic wait_done2(input int budget);
    int n = 0;
    while (done2_seen == 0 && n < budget) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (done2_seen == 0) timeout_fail("wait_done2");
  endtask

  task automatic clear_obs();
    act_ej_cyc.delete();
    act_ej_code.delete();
    done_seen = 0;
    busy_seen = 0;
    codes2.delete();
    done2_seen = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    #1;
    rst = 1'b1;
    @(negedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int e, n;
    model_reset();
    clear_obs();
    repeat (3) @(negedge clock);
    #1;
    rst = 1'b1;
    @(negedge clock);
    #1;

    // 88 from a full inventory: one of each coin, 4 cycles apart, first at E0+2.
    clear_obs();
    drive1(1, 88, 0, 0, 0, e);
    chk("model_88_coins", ej_cyc.size(), 6);
    chk("model_88_done", done_cyc - e, 23);
    wait_idle1(200);
    chk("a_n_ejects", act_ej_cyc.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < act_ej_cyc.size()) begin
        chk("a_eject_time", act_ej_cyc[k] - e, 2 + 4 * k);
        chk("a_eject_code", act_ej_code[k], k);
      end
    end
    chk("a_done_pulses", done_seen, 1);
    for (int d = 0; d < 6; d++) chk("a_model_count", mcount[d], 14);

    // Zero amount: no coins, busy for two cycles, one done pulse.
    clear_obs();
    drive1(1, 0, 0, 0, 0, e);
    wait_idle1(20);
    chk("b_n_ejects", act_ej_cyc.size(), 0);
    chk("b_busy_cycles", busy_seen, 2);
    chk("b_done_pulses", done_seen, 1);

    // Inventory of one each: 100 pays 88 and leaves a shortfall of 12.
    clear_obs();
    drive2(1, 100, 0, 0, 0);
    wait_done2(200);
    chk("c_n_ejects", codes2.size(), 6);
    for (int k = 0; k < 6; k++) if (k < codes2.size()) chk("c_eject_code", codes2[k], k);
    chk("c_short_err", d2_short, 1);
    chk("c_shortfall", d2_fall, 12);
    @(negedge clock);
    #1;
    chk("c_coin_empty", coin_empty2, 6'h3f);

    // Refill on the same edge as a request is visible to the first pick.
    clear_obs();
    drive2(1, 1, 1, 5, 1);
    wait_done2(50);
    chk("d_n_ejects", codes2.size(), 1);
    if (codes2.size() > 0) chk("d_eject_code", codes2[0], 5);
    chk("d_short_err", d2_short, 0);
    chk("d_shortfall", d2_fall, 0);

    // Refill while busy is dropped; refill while idle lands.
    clear_obs();
    drive2(1, 3, 0, 0, 0);
    drive2(0, 0, 1, 4, 5);
    wait_done2(50);
    chk("e_n_ejects", codes2.size(), 0);
    chk("e_short_err", d2_short, 1);
    chk("e_shortfall", d2_fall, 3);
    @(negedge clock);
    #1;
    chk("e_empty_busy_refill", coin_empty2, 6'h3f);
    drive2(0, 0, 1, 4, 5);
    @(negedge clock);
    #1;
    chk("e_empty_idle_refill", coin_empty2, 6'h2f);

    // 150 from fresh counts: three 50s; a mid-transaction strobe is ignored.
    do_reset();
    clear_obs();
    drive1(1, 150, 0, 0, 0, e);
    repeat (4) @(negedge clock);
    #1;
    drive1(1, 40, 0, 0, 0, n);
    wait_idle1(100);
    chk("f_n_ejects", act_ej_cyc.size(), 3);
    for (int k = 0; k < 3; k++) if (k < act_ej_code.size()) chk("f_eject_code", act_ej_code[k], 0);
    chk("f_model_count0", mcount[0], 12);

    // Saturating refill, then the same refill while busy.
    clear_obs();
    drive1(0, 0, 1, 5, 250, e);
    chk("g_model_sat", mcount[5], 255);
    drive1(1, 7, 0, 0, 0, e);
    drive1(0, 0, 1, 5, 250, n);
    wait_idle1(50);
    chk("g_model_busy_refill", mcount[5], 255);
    chk("g_n_ejects", act_ej_cyc.size(), 2);

    // Reset between two ejects of an 88 payout.
    do_reset();
    clear_obs();
    drive1(1, 88, 0, 0, 0, e);
    n = 0;
    while (act_ej_cyc.size() < 2 && n < 50) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (act_ej_cyc.size() < 2) timeout_fail("h_second_eject");
    rst = 1'b0;
    model_reset();
    #1;
    chk("h_rst_busy", busy, 0);
    chk("h_rst_eject", coin_eject, 0);
    chk("h_rst_code", coin_code, 0);
    chk("h_rst_done", done, 0);
    chk("h_rst_short", short_err, 0);
    chk("h_rst_shortfall", shortfall, 0);
    chk("h_rst_empty", coin_empty, 0);
    repeat (6) @(negedge clock);
    #1;
    chk("h_no_more_ejects", act_ej_cyc.size(), 2);
    chk("h_no_done", done_seen, 0);
    rst = 1'b1;
    @(negedge clock);
    #1;
    clear_obs();
    drive1(1, 88, 0, 0, 0, e);
    wait_idle1(200);
    chk("h_n_ejects", act_ej_cyc.size(), 6);
    for (int k = 0; k < 6; k++) if (k < act_ej_code.size()) chk("h_eject_code", act_ej_code[k], k);
    chk("h_done_pulses", done_seen, 1);

    repeat (2) @(negedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
